mod_delay_engine: RTL and testbench
===================================

// Module: mod_delay_engine
// PURPOSE
// Parametrised multi-channel modulated-delay effect (flanger / echo / bypass) with internal circular sample buffer.
// Accepts one packed multi-channel sample per in_valid strobe, mixes dry with delayed (wet) signal, optional feedback.
// Replaces external-SRAM flanger path; sits between input sample buffer and output stage, single clock domain.
// PARAMETERS
// DATA_W     16    bits per channel, signed two's complement
// NUM_CH     2     channels packed in in_data/out_data, ch0 in LSBs
// DEPTH      1024  buffer entries (power of 2); AW = $clog2(DEPTH)
// MIN_DELAY  16    LFO lower delay bound (samples), >= 1
// MAX_DELAY  512   LFO upper delay bound, MIN_DELAY < MAX_DELAY <= DEPTH-1
// LFO_DIV    64    samples per LFO delay step, >= 1
// PORTS
// clk         in   1               system clock
// n_rst       in   1               async active-low reset
// mode        in   2               00 bypass, 01 flanger (LFO delay), 10 echo (fixed delay), 11 = bypass
// fb_shift    in   3               feedback attenuation; 0 = feedback off, else wet>>>fb_shift added to write
// echo_delay  in   AW              echo delay in samples; 0 treated as 1
// in_valid    in   1               sample strobe, honoured only when in_ready=1
// in_data     in   NUM_CH*DATA_W   input sample
// in_ready    out  1               engine idle, can accept sample
// out_valid   out  1               one-cycle pulse, out_data valid
// out_data    out  NUM_CH*DATA_W   processed sample, held until next out_valid
// cur_delay   out  AW              delay applied to most recent sample
// overrun     out  1               sticky: in_valid seen while in_ready=0
// BEHAVIOUR
// - Reset: out_data=0, out_valid=0, in_ready=1, overrun=0, cur_delay=MIN_DELAY; wr_ptr=0, fill_cnt=0, LFO dir=up, lfo_cnt=0.
//   Buffer contents are not reset; fill_cnt gates use of stale entries. Reset mid-operation aborts the sample, no write occurs.
// - FSM IDLE->READ->MIX->IDLE. IDLE: in_ready=1; on in_valid latch in_data, mode, fb_shift, delay; rd_addr=(wr_ptr-d) mod DEPTH.
//   READ: sync RAM read issued. MIX: compute, write RAM[wr_ptr], wr_ptr++ (wraps DEPTH-1->0), fill_cnt++ (saturates at DEPTH).
//   out_valid asserted in cycle after MIX; in_valid at edge k -> out_valid high after edge k+3. Max 1 sample per 3 cycles.
// - Delay d: flanger = LFO value; echo = max(echo_delay,1); bypass = not used.
// - Wet per channel = 0 if d > fill_cnt, else RAM[rd_addr] channel.
// - Bypass: out = in, write value = in (no feedback), LFO frozen; buffer keeps filling for glitch-free mode switch.
// - Flanger/echo: out_ch = (dry + wet) >>> 1, computed at DATA_W+1 bits, floor rounding, no saturation needed.
// - Write value: fb_shift=0 -> dry; else sat(dry + (wet>>>fb_shift)) clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
// - LFO (flanger only): after each processed sample lfo_cnt++; at LFO_DIV-1 reset to 0 and step delay by 1 in dir;
//   reverse dir on reaching MAX_DELAY or MIN_DELAY (triangle, endpoints held exactly one step).
// - in_valid while in_ready=0 is dropped and sets overrun; cleared only by reset.
// - Control inputs are sampled only at acceptance; changes mid-sample have no effect on that sample.
// STRUCTURE
// - Package mod_delay_pkg: mode_t enum (MODE_BYPASS, MODE_FLANGE, MODE_ECHO), state_t (S_IDLE, S_READ, S_MIX), sat helper fn.
// - Sub-module delay_ram: DEPTH x (NUM_CH*DATA_W), one write port, one sync-read port, no reset on array.
// - Top: FSM, pointers, fill counter, LFO, per-channel mix/feedback via generate loop.
// TESTING
// 1 Reset then idle -> out_data=0, out_valid=0, in_ready=1, overrun=0, cur_delay=MIN_DELAY.
// 2 Bypass, in_data=32'h1234_ABCD -> out_valid 3 edges after accept, out_data=32'h1234_ABCD.
// 3 Echo, echo_delay=4, fb 0, impulse ch0=16'h4000 then zeros -> out ch0 16'h2000 at sample 0 and 4, 0 elsewhere.
// 4 Echo, delay=2, fb_shift=1, constant ch0=16'h7FFF x20 -> stored/out never exceeds 16'h7FFF, no sign wrap.
// 5 Flanger MIN=2 MAX=4 LFO_DIV=1 DEPTH=8, 20 samples -> cur_delay 2,3,4,3,2,3..., wr_ptr wraps 7->0 correctly.
// 6 in_valid two consecutive cycles -> second dropped, overrun=1 sticky; n_rst low mid-READ -> all outputs reset values.

Source files
------------

// File: rtl/mod_delay_pkg.sv
// Shared types and helpers for the modulated-delay engine.
package mod_delay_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_FLANGE = 2'b01,
    MODE_ECHO   = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_MIX  = 2'b10
  } state_t;

  // Clamp a sign-extended value to the signed range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat_fn(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      sat_fn = hi;
    end else if (v < lo) begin
      sat_fn = lo;
    end else begin
      sat_fn = v;
    end
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular sample store: one write port, one synchronous read port, array not reset.
module delay_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage write and registered read
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/mod_delay_engine.sv
// Multi-channel flanger / echo / bypass engine around an internal circular buffer.
module mod_delay_engine
  import mod_delay_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 1024,
  parameter int MIN_DELAY = 16,
  parameter int MAX_DELAY = 512,
  parameter int LFO_DIV   = 64,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = NUM_CH * DATA_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [1:0]    mode,
  input  logic [2:0]    fb_shift,
  input  logic [AW-1:0] echo_delay,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] cur_delay,
  output logic          overrun
);

  localparam int LW = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

  state_t        state_q, state_d;
  logic          in_ready_s, rd_en_s, mix_en_s, accept_s;
  mode_t         mode_s, mode_q;
  logic [AW-1:0] delay_s, rd_addr_q, wr_ptr_q, lfo_q, cur_delay_q;
  logic [AW:0]   fill_q;
  logic [LW-1:0] lfo_cnt_q;
  logic          lfo_up_q, wet_en_q, pend_q, out_valid_q, overrun_q;
  logic [2:0]    fb_q;
  logic [DW-1:0] data_q, res_q, out_data_q, rd_data_s, mix_out_s, wr_data_s;

  assign accept_s  = in_valid & in_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cur_delay = cur_delay_q;
  assign overrun   = overrun_q;

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_READ;
        else          state_d = S_IDLE;
      end
      S_READ:  state_d = S_MIX;
      S_MIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_s = 1'b0;
    rd_en_s    = 1'b0;
    mix_en_s   = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_s = 1'b1;
      S_READ:  rd_en_s    = 1'b1;
      S_MIX:   mix_en_s   = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Mode decode (11 folds into bypass) and delay selection at acceptance
  always_comb begin
    case (mode)
      2'b01:   mode_s = MODE_FLANGE;
      2'b10:   mode_s = MODE_ECHO;
      default: mode_s = MODE_BYPASS;
    endcase
    if (mode_s == MODE_FLANGE) begin
      delay_s = lfo_q;
    end else if (echo_delay == '0) begin
      delay_s = AW'(1);
    end else begin
      delay_s = echo_delay;
    end
  end

  // Sample and control capture on acceptance
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q      <= '0;
      mode_q      <= MODE_BYPASS;
      fb_q        <= 3'd0;
      rd_addr_q   <= '0;
      wet_en_q    <= 1'b0;
      cur_delay_q <= AW'(MIN_DELAY);
    end else if (accept_s) begin
      data_q    <= in_data;
      mode_q    <= mode_s;
      fb_q      <= fb_shift;
      rd_addr_q <= wr_ptr_q - delay_s;
      // Entries older than the fill level are stale and must read as silence
      wet_en_q  <= ({1'b0, delay_s} <= fill_q);
      if (mode_s != MODE_BYPASS) begin
        cur_delay_q <= delay_s;
      end
    end
  end

  // Write pointer, fill level and triangle LFO advance once per processed sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      lfo_q     <= AW'(MIN_DELAY);
      lfo_up_q  <= 1'b1;
      lfo_cnt_q <= '0;
    end else if (mix_en_s) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fill_q != (AW+1)'(DEPTH)) begin
        fill_q <= fill_q + (AW+1)'(1);
      end
      if (mode_q == MODE_FLANGE) begin
        if (lfo_cnt_q == LW'(LFO_DIV - 1)) begin
          lfo_cnt_q <= '0;
          if (lfo_up_q) begin
            lfo_q <= lfo_q + AW'(1);
            if (lfo_q == AW'(MAX_DELAY - 1)) lfo_up_q <= 1'b0;
          end else begin
            lfo_q <= lfo_q - AW'(1);
            if (lfo_q == AW'(MIN_DELAY + 1)) lfo_up_q <= 1'b1;
          end
        end else begin
          lfo_cnt_q <= lfo_cnt_q + LW'(1);
        end
      end
    end
  end

  // Result staging, output register and sticky overrun flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q      <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= mix_en_s;
      out_valid_q <= pend_q;
      if (mix_en_s) res_q <= mix_out_s;
      if (pend_q)   out_data_q <= res_q;
      if (in_valid && !in_ready_s) overrun_q <= 1'b1;
    end
  end

  delay_ram #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mix_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_s),
    .re_i    (rd_en_s),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data_s)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] dry_s, wet_s, fbw_s, sat_s, avg_s;
    logic signed [DATA_W:0]   sum_s;
    logic signed [31:0]       fbsum_s;

    assign dry_s   = data_q[c*DATA_W +: DATA_W];
    assign wet_s   = wet_en_q ? rd_data_s[c*DATA_W +: DATA_W] : '0;
    assign fbw_s   = wet_s >>> fb_q;
    assign sum_s   = {dry_s[DATA_W-1], dry_s} + {wet_s[DATA_W-1], wet_s};
    assign avg_s   = DATA_W'(sum_s >>> 1);
    assign fbsum_s = $signed({{(32-DATA_W){dry_s[DATA_W-1]}}, dry_s})
                   + $signed({{(32-DATA_W){fbw_s[DATA_W-1]}}, fbw_s});
    assign sat_s   = DATA_W'(sat_fn(fbsum_s, DATA_W));

    assign mix_out_s[c*DATA_W +: DATA_W] = (mode_q == MODE_BYPASS) ? dry_s : avg_s;
    assign wr_data_s[c*DATA_W +: DATA_W] =
        ((mode_q == MODE_BYPASS) || (fb_q == 3'd0)) ? dry_s : sat_s;
  end

endmodule

// File: tb/tb_mod_delay_engine.sv
// Table-driven scoreboard bench for mod_delay_engine (default and small flanger configs).
module tb_mod_delay_engine;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  fb;
    logic [9:0]  ed;
    logic [31:0] din;
    logic [31:0] dout;
    logic [9:0]  dly;
  } vec_t;

  logic        clk, n_rst, in_valid;
  logic [1:0]  mode;
  logic [2:0]  fb_shift;
  logic [9:0]  echo_delay;
  logic [31:0] in_data;
  logic        in_ready, out_valid, overrun;
  logic [31:0] out_data;
  logic [9:0]  cur_delay;
  logic        f_in_ready, f_out_valid, f_overrun;
  logic [31:0] f_out_data;
  logic [2:0]  f_cur_delay;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  vec_t vt[39];

  mod_delay_engine dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .fb_shift(fb_shift), .echo_delay(echo_delay),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .cur_delay(cur_delay), .overrun(overrun)
  );

  mod_delay_engine #(.DEPTH(8), .MIN_DELAY(2), .MAX_DELAY(4), .LFO_DIV(1)) dut_f (
    .clk(clk), .n_rst(n_rst), .mode(mode), .fb_shift(fb_shift), .echo_delay(echo_delay[2:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(f_in_ready), .out_valid(f_out_valid),
    .out_data(f_out_data), .cur_delay(f_cur_delay), .overrun(f_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check_idle);
    n_rst = 1'b0; in_valid = 1'b0; mode = 2'b00; fb_shift = 3'd0;
    echo_delay = 10'd0; in_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    if (check_idle) begin
      @(negedge clk);
      chk("reset out_data", out_data, 32'h0);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset overrun", {31'd0, overrun}, 32'd0);
      chk("reset cur_delay", {22'd0, cur_delay}, 32'd16);
    end
  endtask

  // Drive one sample, push its expectation, then pop and compare when out_valid appears.
  task automatic send(input bit use_f, input logic [1:0] m, input logic [2:0] fb, input logic [9:0] ed,
                      input logic [31:0] din, input logic [31:0] exp_o, input logic [9:0] exp_d,
                      input string tag);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, use_f ? f_in_ready : in_ready}, 32'd1);
    mode = m; fb_shift = fb; echo_delay = ed; in_data = din; in_valid = 1'b1;
    exp_q.push_back(exp_o);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = ~m; fb_shift = ~fb; echo_delay = ed + 10'd3; in_data = ~din;
    lat = 0;
    while (!(use_f ? f_out_valid : out_valid) && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd3);
    e = exp_q.pop_front();
    if (use_f ? f_out_valid : out_valid) begin
      chk({tag, " out_data"}, use_f ? f_out_data : out_data, e);
      chk({tag, " cur_delay"}, use_f ? {29'd0, f_cur_delay} : {22'd0, cur_delay}, {22'd0, exp_d});
      @(posedge clk); #1;
      chk({tag, " pulse"}, {31'd0, use_f ? f_out_valid : out_valid}, 32'd0);
    end
  endtask

  task automatic run_group(input int lo, input int hi, input string tag);
    do_reset(1'b0);
    for (int i = lo; i <= hi; i++) begin
      send(1'b0, vt[i].mode, vt[i].fb, vt[i].ed, vt[i].din, vt[i].dout, vt[i].dly, tag);
    end
  endtask

  initial begin
    int pulses;
    int dd;
    bit up;
    logic [15:0] x, wet, ch1;

    vt[0] = '{2'b00, 3'd0, 10'd0, 32'h1234ABCD, 32'h1234ABCD, 10'd16};
    vt[1] = '{2'b11, 3'd5, 10'd7, 32'hDEADBEEF, 32'hDEADBEEF, 10'd16};
    vt[2] = '{2'b00, 3'd1, 10'd3, 32'h80007FFF, 32'h80007FFF, 10'd16};
    for (int i = 0; i < 10; i++)
      vt[3+i] = '{2'b10, 3'd0, 10'd4, (i == 0) ? 32'h00004000 : 32'h0,
                  (i == 0 || i == 4) ? 32'h00002000 : 32'h0, 10'd4};
    for (int i = 0; i < 20; i++)
      vt[13+i] = '{2'b10, 3'd1, 10'd2, 32'h00007FFF, (i < 2) ? 32'h00003FFF : 32'h00007FFF, 10'd2};
    vt[33] = '{2'b10, 3'd0, 10'd0, 32'h8000FFFF, 32'hC000FFFF, 10'd1};
    vt[34] = '{2'b10, 3'd0, 10'd0, 32'h80000000, 32'h8000FFFF, 10'd1};
    vt[35] = '{2'b10, 3'd0, 10'd0, 32'h80000003, 32'h80000001, 10'd1};
    vt[36] = '{2'b10, 3'd2, 10'd1, 32'h00008000, 32'h0000C000, 10'd1};
    vt[37] = '{2'b10, 3'd2, 10'd1, 32'h00008000, 32'h00008000, 10'd1};
    vt[38] = '{2'b10, 3'd2, 10'd1, 32'h00000000, 32'h0000C000, 10'd1};

    do_reset(1'b1);
    run_group(0, 2, "bypass");
    run_group(3, 12, "echo_impulse");
    run_group(13, 32, "echo_sat_hi");
    run_group(33, 35, "echo_round");
    run_group(36, 38, "echo_sat_lo");

    // Small flanger: triangle delay 2..4 and pointer wrap in an 8-entry buffer
    do_reset(1'b0);
    dd = 2; up = 1'b1;
    for (int n = 0; n < 20; n++) begin
      x   = 16'(16 * (n + 1));
      wet = (dd <= n) ? 16'(16 * (n - dd + 1)) : 16'h0;
      ch1 = (dd <= n) ? 16'h0100 : 16'h0080;
      send(1'b1, 2'b01, 3'd0, 10'd0, {16'h0100, x}, {ch1, 16'((x + wet) >> 1)}, 10'(dd), "flange");
      if (up) begin
        dd++;
        if (dd == 4) up = 1'b0;
      end else begin
        dd--;
        if (dd == 2) up = 1'b1;
      end
    end
    chk("flange overrun", {31'd0, f_overrun}, 32'd0);

    // Back-to-back strobes: second one dropped, overrun sticky
    do_reset(1'b0);
    @(negedge clk);
    mode = 2'b00; in_data = 32'hA5A55A5A; in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'h0;
    chk("overrun set", {31'd0, overrun}, 32'd1);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("overrun pulses", pulses, 32'd1);
    chk("overrun data", out_data, 32'hA5A55A5A);
    send(1'b0, 2'b00, 3'd0, 10'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 10'd16, "after_overrun");
    chk("overrun sticky", {31'd0, overrun}, 32'd1);

    // Reset asserted while a sample sits in READ
    @(negedge clk);
    mode = 2'b10; echo_delay = 10'd5; in_data = 32'h11112222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst overrun", {31'd0, overrun}, 32'd0);
    chk("midrst cur_delay", {22'd0, cur_delay}, 32'd16);
    chk("midrst out_data", out_data, 32'h0);
    @(negedge clk) n_rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("midrst aborted", pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
